// File: rtl/demux1x4_buf.sv
// Registered 1-to-4 demultiplexer with a one-entry skid buffer per channel.
// Optional accepted-word counter enabled by defining DEMUX1X4_BUF_COUNT_EN.
module demux1x4_buf #(
    parameter int WIDTH    = 16,
    parameter int RR_START = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [WIDTH-1:0]   in_data,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         select,
    input  logic               auto_mode,
    output logic [4*WIDTH-1:0] out_data,
    output logic [3:0]         out_valid,
    input  logic [3:0]         out_ready,
    output logic [1:0]         rr_ptr,
    output logic [15:0]        word_count
);

    // Handshake: a word moves on any cycle where valid and ready are both high.
    // in_ready is derived only from the destination channel, never from in_valid.
    logic [1:0] dst;
    logic       accept;

    assign dst      = auto_mode ? rr_ptr : select;
    assign in_ready = ~out_valid[dst] | out_ready[dst];
    assign accept   = in_valid & in_ready;

    // A refill takes priority over a drain, so a draining buffer never bubbles.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 4'b0000;
            out_data  <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (accept && (dst == 2'(i))) begin
                    out_valid[i]                <= 1'b1;
                    out_data[i*WIDTH +: WIDTH]  <= in_data;
                end else if (out_ready[i]) begin
                    out_valid[i] <= 1'b0;
                end
            end
        end
    end

    // Pointer only moves on accepts in auto mode; stalls never skip a channel.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr <= 2'(RR_START);
        end else if (accept && auto_mode) begin
            rr_ptr <= rr_ptr + 2'd1;
        end
    end

`ifdef DEMUX1X4_BUF_COUNT_EN
    logic [15:0] count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= 16'h0000;
        end else if (accept) begin
            count_q <= count_q + 16'h0001;
        end
    end

    assign word_count = count_q;
`else
    assign word_count = 16'h0000;
`endif

endmodule
